jhash_ctl: RTL and testbench

Sequencing controller for the jhash datapath. Consumes the three-word stream produced by the jhash input stage, absorbs each 96-bit block into the a/b/c state, and steps the lookup3 `mix` and `final` rounds one line per cycle. Presents a 32-bit hash with a valid/ack handshake. Sits between the jhash input stage and the result FIFO/register interface.

---
 rtl/jhash_ctl.sv | 185 ++++++++++++++++++
 tb/tb_jhash_ctl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jhash_ctl.sv
// jhash_ctl: lookup3 sequencing controller for the jhash datapath.
// Absorbs 96-bit blocks into the a/b/c state, steps the mix and final rounds,
// and presents the final c as the hash with a valid/ack handshake.
// Build option: define JHASH_CTL_MIX2_EN to evaluate two round lines per cycle.
module jhash_ctl #(
   parameter logic [31:0] INIT_CONST = 32'hdeadbeef
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] length,
   input  logic [31:0] initval,
   input  logic [31:0] stream_data0,
   input  logic [31:0] stream_data1,
   input  logic [31:0] stream_data2,
   input  logic        stream_valid,
   input  logic        stream_done,
   output logic        stream_ack,
   output logic [31:0] hash_value,
   output logic        hash_valid,
   input  logic        hash_ack,
   output logic        busy,
   output logic        len_err
);

   typedef enum logic [2:0] {S_IDLE, S_ABSORB, S_MIX, S_FINAL, S_DONE} state_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
   } abc_t;

`ifdef JHASH_CTL_MIX2_EN
   localparam logic [2:0] MIX_LAST = 3'd2;
   localparam logic [2:0] FIN_LAST = 3'd3;
`else
   localparam logic [2:0] MIX_LAST = 3'd5;
   localparam logic [2:0] FIN_LAST = 3'd6;
`endif

   function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned r);
      return (x << r) | (x >> (32 - r));
   endfunction

   // One lookup3 line; fin selects the final round table, idx the line within it.
   function automatic abc_t do_line(input logic fin, input logic [2:0] idx, input abc_t s);
      abc_t o;
      o = s;
      if (!fin) begin
         case (idx)
            3'd0:    begin o.a = (s.a - s.c) ^ rotl(s.c, 4);  o.c = s.c + s.b; end
            3'd1:    begin o.b = (s.b - s.a) ^ rotl(s.a, 6);  o.a = s.a + s.c; end
            3'd2:    begin o.c = (s.c - s.b) ^ rotl(s.b, 8);  o.b = s.b + s.a; end
            3'd3:    begin o.a = (s.a - s.c) ^ rotl(s.c, 16); o.c = s.c + s.b; end
            3'd4:    begin o.b = (s.b - s.a) ^ rotl(s.a, 19); o.a = s.a + s.c; end
            3'd5:    begin o.c = (s.c - s.b) ^ rotl(s.b, 4);  o.b = s.b + s.a; end
            default: o = s;
         endcase
      end else begin
         case (idx)
            3'd0:    o.c = (s.c ^ s.b) - rotl(s.b, 14);
            3'd1:    o.a = (s.a ^ s.c) - rotl(s.c, 11);
            3'd2:    o.b = (s.b ^ s.a) - rotl(s.a, 25);
            3'd3:    o.c = (s.c ^ s.b) - rotl(s.b, 16);
            3'd4:    o.a = (s.a ^ s.c) - rotl(s.c, 4);
            3'd5:    o.b = (s.b ^ s.a) - rotl(s.a, 14);
            default: o.c = (s.c ^ s.b) - rotl(s.b, 24);
         endcase
      end
      return o;
   endfunction

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_step, w_step_nxt;
   abc_t        r_s, w_s_nxt, w_line1, w_line2;
   logic [31:0] r_rem, w_rem_nxt;
   logic        r_len_err, w_len_err_nxt;
   logic        w_fin;
   logic [2:0]  w_idx;
   logic [31:0] w_seed;

   assign w_seed = INIT_CONST + (length << 2) + initval;

   // Round datapath: the line(s) selected by the step counter for this cycle.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      w_fin   = (r_state == S_FINAL);
`ifdef JHASH_CTL_MIX2_EN
      w_idx   = {r_step[1:0], 1'b0};
      w_line1 = do_line(w_fin, w_idx, r_s);
      // The fourth final cycle has only line 7 left to evaluate.
      w_line2 = (w_fin && r_step == FIN_LAST) ? w_line1
                                              : do_line(w_fin, w_idx | 3'd1, w_line1);
`else
      w_idx   = r_step;
      w_line1 = do_line(w_fin, w_idx, r_s);
      w_line2 = w_line1;
`endif
   end

   // Next-state and state-update logic for the sequencing FSM.
   always_comb begin
      w_state_nxt   = r_state;
      w_step_nxt    = r_step;
      w_s_nxt       = r_s;
      w_rem_nxt     = r_rem;
      w_len_err_nxt = r_len_err;
      stream_ack    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_s_nxt       = '{a: w_seed, b: w_seed, c: w_seed};
               w_rem_nxt     = length;
               w_len_err_nxt = 1'b0;
               w_step_nxt    = 3'd0;
               w_state_nxt   = (length == 32'd0) ? S_DONE : S_ABSORB;
            end
         end
         S_ABSORB: begin
            stream_ack = stream_valid;
            if (stream_valid) begin
               w_s_nxt.a = r_s.a + stream_data0;
               if (r_rem >= 32'd2) w_s_nxt.b = r_s.b + stream_data1;
               if (r_rem >= 32'd3) w_s_nxt.c = r_s.c + stream_data2;
               // Sequencing follows rem; stream_done only feeds the error flag.
               if (stream_done != (r_rem <= 32'd3)) w_len_err_nxt = 1'b1;
               w_step_nxt = 3'd0;
               if (r_rem > 32'd3) begin
                  w_rem_nxt   = r_rem - 32'd3;
                  w_state_nxt = S_MIX;
               end else begin
                  w_state_nxt = S_FINAL;
               end
            end
         end
         S_MIX: begin
            w_s_nxt = w_line2;
            if (r_step == MIX_LAST) begin
               w_step_nxt  = 3'd0;
               w_state_nxt = S_ABSORB;
            end else begin
               w_step_nxt = r_step + 3'd1;
            end
         end
         S_FINAL: begin
            w_s_nxt = w_line2;
            if (r_step == FIN_LAST) begin
               w_step_nxt  = 3'd0;
               w_state_nxt = S_DONE;
            end else begin
               w_step_nxt = r_step + 3'd1;
            end
         end
         S_DONE: begin
            if (hash_ack) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep all registers updating off the same pre-edge values.
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_step    <= 3'd0;
         r_s       <= '0;
         r_rem     <= 32'd0;
         r_len_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_step    <= w_step_nxt;
         r_s       <= w_s_nxt;
         r_rem     <= w_rem_nxt;
         r_len_err <= w_len_err_nxt;
      end
   end

   assign hash_valid = (r_state == S_DONE);
   assign hash_value = hash_valid ? r_s.c : 32'd0;
   assign busy       = (r_state != S_IDLE);
   assign len_err    = r_len_err;

endmodule

// File: tb/tb_jhash_ctl.sv
// tb_jhash_ctl: scoreboard bench for jhash_ctl against a C-style lookup3 hashword model.
module tb_jhash_ctl;

`ifdef JHASH_CTL_MIX2_EN
   localparam int LAT_FIRST = 6;
   localparam int LAT_BLK   = 4;
   localparam int MIX_CYC   = 3;
`else
   localparam int LAT_FIRST = 9;
   localparam int LAT_BLK   = 7;
   localparam int MIX_CYC   = 6;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] length = 32'd0;
   logic [31:0] initval = 32'd0;
   logic [31:0] stream_data0 = 32'd0;
   logic [31:0] stream_data1 = 32'd0;
   logic [31:0] stream_data2 = 32'd0;
   logic        stream_valid = 1'b0;
   logic        stream_done = 1'b0;
   logic        hash_ack = 1'b0;
   logic        stream_ack;
   logic [31:0] hash_value;
   logic        hash_valid;
   logic        busy;
   logic        len_err;

   always #5 clk = ~clk;

   jhash_ctl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .length       (length),
      .initval      (initval),
      .stream_data0 (stream_data0),
      .stream_data1 (stream_data1),
      .stream_data2 (stream_data2),
      .stream_valid (stream_valid),
      .stream_done  (stream_done),
      .stream_ack   (stream_ack),
      .hash_value   (hash_value),
      .hash_valid   (hash_valid),
      .hash_ack     (hash_ack),
      .busy         (busy),
      .len_err      (len_err)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] val_q[$];
   int          lat_q[$];
   logic        err_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rot(input logic [31:0] x, input int r);
      return (x << r) | (x >> (32 - r));
   endfunction

   // Reference hashword() over the key k[i] = kbase + i.
   function automatic logic [31:0] hashword(input int len, input logic [31:0] iv,
                                            input logic [31:0] kbase);
      logic [31:0] a, b, c;
      int n, i;
      a = 32'hdeadbeef + (32'(len) << 2) + iv;
      b = a;
      c = a;
      n = len;
      i = 0;
      while (n > 3) begin
         a += kbase + 32'(i);
         b += kbase + 32'(i + 1);
         c += kbase + 32'(i + 2);
         a -= c; a ^= rot(c, 4);  c += b;
         b -= a; b ^= rot(a, 6);  a += c;
         c -= b; c ^= rot(b, 8);  b += a;
         a -= c; a ^= rot(c, 16); c += b;
         b -= a; b ^= rot(a, 19); a += c;
         c -= b; c ^= rot(b, 4);  b += a;
         n -= 3;
         i += 3;
      end
      if (n >= 3) c += kbase + 32'(i + 2);
      if (n >= 2) b += kbase + 32'(i + 1);
      if (n >= 1) a += kbase + 32'(i);
      if (n > 0) begin
         c ^= b; c -= rot(b, 14);
         a ^= c; a -= rot(c, 11);
         b ^= a; b -= rot(a, 25);
         c ^= b; c -= rot(b, 16);
         a ^= c; a -= rot(c, 4);
         b ^= a; b -= rot(a, 14);
         c ^= b; c -= rot(b, 24);
      end
      return c;
   endfunction

   // One complete hash: push expectations, stream blocks, pop and compare at hash_valid.
   task automatic run_hash(input int len, input logic [31:0] iv, input logic [31:0] kbase,
                           input int stall_blk, input int stall_n, input bit done_bad,
                           input int ack_delay, output logic [31:0] got);
      int nblk, blk, gap, stall_left, cyc, n_ack, el;
      logic exp_ack, ee;
      bit seen;
      logic [31:0] ev;
      got  = 32'd0;
      nblk = (len + 2) / 3;
      val_q.push_back(hashword(len, iv, kbase));
      lat_q.push_back((len == 0) ? 1 : LAT_FIRST + LAT_BLK * (nblk - 1) +
                      ((stall_blk >= 0 && stall_blk < nblk) ? stall_n : 0));
      err_q.push_back(done_bad);

      start   = 1'b1;
      length  = 32'(len);
      initval = iv;
      @(posedge clk);
      #1;
      start  = 1'b0;
      length = 32'd0;
      cyc    = 1;
      check("len_err_at_start", 32'(len_err), 32'd0);

      blk = 0; gap = 0; stall_left = stall_n; n_ack = 0; seen = 1'b0;
      while (!seen) begin
         if (hash_valid) begin
            seen = 1'b1;
         end else if (cyc > 400) begin
            check("timeout_hash_valid", 32'(hash_valid), 32'd1);
            void'(val_q.pop_front());
            void'(lat_q.pop_front());
            void'(err_q.pop_front());
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            return;
         end else begin
            exp_ack = (blk < nblk) && (gap == 0) && !(blk == stall_blk && stall_left > 0);
            stream_valid = exp_ack;
            stream_data0 = (blk * 3 + 0 < len) ? kbase + 32'(blk * 3 + 0) : 32'ha5a5a5a5;
            stream_data1 = (blk * 3 + 1 < len) ? kbase + 32'(blk * 3 + 1) : 32'ha5a5a5a5;
            stream_data2 = (blk * 3 + 2 < len) ? kbase + 32'(blk * 3 + 2) : 32'ha5a5a5a5;
            stream_done  = done_bad ? (blk == 0) : (blk == nblk - 1);
            @(negedge clk);
            check("stream_ack", 32'(stream_ack), 32'(exp_ack));
            if (stream_ack) n_ack++;
            if (exp_ack) begin
               blk++;
               gap = MIX_CYC;
            end else if (gap > 0) begin
               gap--;
            end else if (blk == stall_blk && stall_left > 0) begin
               stall_left--;
            end
            @(posedge clk);
            #1;
            cyc++;
            stream_valid = 1'b0;
         end
      end

      ev = val_q.pop_front();
      el = lat_q.pop_front();
      ee = err_q.pop_front();
      check("hash_value", hash_value, ev);
      check("latency", 32'(cyc), 32'(el));
      check("ack_count", 32'(n_ack), 32'(nblk));
      check("len_err", 32'(len_err), 32'(ee));
      got = hash_value;

      for (int i = 0; i < ack_delay; i++) begin
         if (i == 1) begin
            start  = 1'b1;
            length = 32'd3;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         check("hold_valid", 32'(hash_valid), 32'd1);
         check("hold_value", hash_value, ev);
      end
      hash_ack = 1'b1;
      @(posedge clk);
      #1;
      hash_ack = 1'b0;
      check("post_ack_valid", 32'(hash_valid), 32'd0);
      check("post_ack_busy", 32'(busy), 32'd0);
   endtask

   // Reset during the mix round must return every output to its reset value.
   task automatic abort_test();
      start        = 1'b1;
      length       = 32'd6;
      initval      = 32'd5;
      stream_valid = 1'b1;
      stream_done  = 1'b1;
      stream_data0 = 32'd1;
      stream_data1 = 32'd2;
      stream_data2 = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      check("abort_len_err_set", 32'(len_err), 32'd1);
      check("abort_busy", 32'(busy), 32'd1);
      check("ack_in_mix", 32'(stream_ack), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort_ack", 32'(stream_ack), 32'd0);
      check("abort_valid", 32'(hash_valid), 32'd0);
      check("abort_value", hash_value, 32'd0);
      check("abort_busy_clr", 32'(busy), 32'd0);
      check("abort_len_err_clr", 32'(len_err), 32'd0);
      rst_n        = 1'b1;
      stream_valid = 1'b0;
      stream_done  = 1'b0;
   endtask

   initial begin
      logic [31:0] got;
      int rlen[6];
      rlen = '{1, 2, 5, 8, 9, 10};
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", 32'(stream_ack), 32'd0);
      check("rst_valid", 32'(hash_valid), 32'd0);
      check("rst_value", hash_value, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_len_err", 32'(len_err), 32'd0);
      rst_n = 1'b1;

      run_hash(0, 32'h12345678, 32'd0, -1, 0, 1'b0, 0, got);
      check("zero_len_hash", got, 32'hf0e21567);
      run_hash(3, 32'd0, 32'd1, -1, 0, 1'b0, 5, got);
      run_hash(7, 32'h9e3779b9, 32'd0, 1, 2, 1'b0, 0, got);
      run_hash(6, 32'h00000042, 32'd100, -1, 0, 1'b1, 0, got);
      run_hash(4, 32'h00000001, 32'd200, -1, 0, 1'b0, 0, got);
      abort_test();
      for (int i = 0; i < 6; i++)
         run_hash(rlen[i], $urandom, $urandom, (i == 3) ? 2 : -1, 1, 1'b0, 1, got);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
